button_event_arbiter: RTL and testbench
=======================================

Name: button_event_arbiter

Overview:
- Front-end controller for all user push-buttons of the pet game.
- Per button: synchronises and debounces the raw input, then classifies each press as SHORT (released before LONG_MS) or LONG (held LONG_MS, the 5 s hold-to-reset gesture).
- Buffers one event per button and arbitrates the pending events onto a single valid/ready event port consumed by the game FSM.

Parameters:
- N_BTN, 4, number of buttons (2..8).
- TICK_DIV, 50000, clk cycles per 1 ms tick (50 MHz board clock).
- DEBOUNCE_MS, 20, ticks a synchronised level must stay stable to be accepted.
- LONG_MS, 5000, ticks of continuous hold that make a LONG press.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- btn_in  in  N_BTN  raw button levels, active-high, asynchronous to clk.
- ev_valid  out  1  event available.
- ev_ready  in  1  consumer accepts the event this cycle.
- ev_btn  out  $clog2(N_BTN)  index of the button that produced the event.
- ev_long  out  1  1 = LONG press, 0 = SHORT press.
- pending  out  N_BTN  per-button event-slot occupancy.
- overrun  out  N_BTN  sticky per button; an event was dropped because its slot was full.

Behaviour:
- Reset values: all outputs 0; all counters 0; every classifier in IDLE; debounced levels 0; round-robin pointer 0.
- Tick: free-running counter 0..TICK_DIV-1. tick pulses for 1 cycle when the count wraps. Shared by all buttons.
- Sync: 2-FF synchroniser per btn_in bit.
- Debounce:
  - Per-button stability counter resets whenever the synchronised level differs from the debounced level.
  - Otherwise it increments on tick.
  - When it reaches DEBOUNCE_MS, the debounced level takes the new value.
- Classifier FSM per button, hold counter saturating at LONG_MS:
  - IDLE: on debounced rise, clear hold counter and go to HELD.
  - HELD: hold counter increments on tick.
    - Debounced fall with hold < LONG_MS: raise a SHORT event and go to IDLE.
    - Hold reaches LONG_MS while still pressed: raise a LONG event and go to WAIT_REL.
  - WAIT_REL: no further events. Go to IDLE on debounced fall.
- Event slot per button (pending bit + long bit):
  - An event raised while the slot is empty is stored.
  - An event raised while the slot is full and not being unloaded that cycle is dropped, and the overrun bit sets (cleared only by rst).
  - Event raised in the same cycle the slot is unloaded: the new event is stored and overrun does not set.
- Output register:
  - Loads when ev_valid==0, or when ev_valid&&ev_ready (back-to-back transfer allowed, 1 event/cycle throughput).
  - On load: the winner slot is cleared; ev_valid=1; ev_btn and ev_long are taken from the winner.
  - If nothing is pending at load time, ev_valid drops to 0.
  - ev_btn and ev_long are held stable while ev_valid && !ev_ready.
- Latency: event raised in cycle N → slot set at edge N+1 → ev_valid at edge N+2, provided the output register is free.
- Arbitration: fixed priority, lowest index wins.
- Reset mid-operation: all state clears immediately.
  - A button still held when rst releases is debounced as a fresh press.
  - Hold time is counted from the debounce acceptance point.
- Counter widths: $clog2(TICK_DIV), $clog2(DEBOUNCE_MS+1), $clog2(LONG_MS+1).

Optional Feature:
- Macro BTN_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - The search starts at index (last granted + 1) mod N_BTN.
  - The pointer updates only on a load that has a winner.
- Undefined: fixed priority, lowest index wins; no pointer register.

Decomposition:
- Package btn_pkg:
  - Classifier state encodings IDLE=0, HELD=1, WAIT_REL=2.
  - Event field widths.
  - Event type constants EV_SHORT=0, EV_LONG=1.
- Sub-module btn_press_classifier: one instance per button (generate loop). Contains the synchroniser, debouncer, classifier FSM and hold counter. Outputs a 1-cycle ev_raise and ev_is_long.
- Top level contains: tick generator, event slots, arbiter, output register.

Test Plan (sim params: TICK_DIV=4, DEBOUNCE_MS=3, LONG_MS=10):
- Short press: btn_in[1] high 6 ticks then low → one event: ev_btn=1, ev_long=0. Accepted with ev_ready=1; pending returns to 0.
- Long press: btn_in[0] held 20 ticks → one event (0,1) raised at hold=10 while still pressed; no event on release.
- Bounce: btn_in[2] toggles every 4 clk for 40 clk, then stays low → no event.
- Contention: buttons 0 and 3 raise events in the same cycle, ev_ready=1.
  - Fixed priority: events for 3 then 0? No: fixed gives 0 then 3 on consecutive cycles.
  - BTN_ROUND_ROBIN_EN with last grant 0: 3 then 0.
- Overrun: ev_ready=0; two short presses on button 2 → first stays in ev_valid; the second fills the slot; a third press sets overrun[2]=1. The data shown is unchanged until ready.
- Async reset: assert rst mid-HELD on button 1 → outputs 0 immediately; no event. Button still held after release → a LONG event after 3+10 ticks.

Source files
------------

// File: rtl/btn_pkg.sv
// ============================================================================
// Module  : btn_pkg
// Brief   : Shared classifier state encodings, event type codes and width helper
//           for button_event_arbiter.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package btn_pkg;

    localparam int unsigned ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE     = 2'd0;
    localparam logic [ST_W-1:0] ST_HELD     = 2'd1;
    localparam logic [ST_W-1:0] ST_WAIT_REL = 2'd2;

    localparam logic EV_SHORT = 1'b0;
    localparam logic EV_LONG  = 1'b1;

    // Bits needed to encode n distinct values, never less than one.
    function automatic int unsigned width_of(input int unsigned n_values);
        return (n_values <= 2) ? 1 : $clog2(n_values);
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_press_classifier.sv
// ============================================================================
// Module  : btn_press_classifier
// Brief   : Per-button synchroniser, tick-based debouncer and SHORT/LONG press
//           classifier; emits a one-cycle event pulse.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_press_classifier
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 5000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    input  logic i_tick,
    output logic o_ev_raise,
    output logic o_ev_is_long
);

    localparam int unsigned DB_W   = width_of(DEBOUNCE_MS + 1);
    localparam int unsigned HOLD_W = width_of(LONG_MS + 1);

    localparam logic [DB_W-1:0]   c_db_last   = DB_W'(DEBOUNCE_MS - 1);
    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(LONG_MS - 1);
    localparam logic [HOLD_W-1:0] c_hold_max  = HOLD_W'(LONG_MS);

    logic [1:0]        r_sync;
    logic              r_db;
    logic [DB_W-1:0]   r_stab;
    logic [ST_W-1:0]   r_state;
    logic [HOLD_W-1:0] r_hold;
    logic              r_ev_raise;
    logic              r_ev_is_long;

    logic w_accept;
    logic w_rise;
    logic w_fall;

    // The stability count finishes on the tick that would make it DEBOUNCE_MS.
    assign w_accept = (r_sync[1] != r_db) && i_tick && (r_stab == c_db_last);
    assign w_rise   = w_accept &&  r_sync[1];
    assign w_fall   = w_accept && !r_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_db   <= 1'b0;
            r_stab <= '0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            if (r_sync[1] == r_db) begin
                r_stab <= '0;
            end else if (i_tick) begin
                if (r_stab == c_db_last) begin
                    r_db   <= r_sync[1];
                    r_stab <= '0;
                end else begin
                    r_stab <= r_stab + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_hold       <= '0;
            r_ev_raise   <= 1'b0;
            r_ev_is_long <= EV_SHORT;
        end else begin
            r_ev_raise <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_hold  <= '0;
                        r_state <= ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (w_fall) begin
                        r_ev_raise   <= 1'b1;
                        r_ev_is_long <= EV_SHORT;
                        r_state      <= ST_IDLE;
                    end else if (i_tick) begin
                        if (r_hold == c_hold_last) begin
                            r_hold       <= c_hold_max;
                            r_ev_raise   <= 1'b1;
                            r_ev_is_long <= EV_LONG;
                            r_state      <= ST_WAIT_REL;
                        end else begin
                            r_hold <= r_hold + 1'b1;
                        end
                    end
                end
                ST_WAIT_REL: begin
                    if (w_fall) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ev_raise   = r_ev_raise;
    assign o_ev_is_long = r_ev_is_long;

endmodule

`default_nettype wire

// File: rtl/button_event_arbiter.sv
// ============================================================================
// Module  : button_event_arbiter
// Brief   : Debounced SHORT/LONG press events from N_BTN buttons, one slot per
//           button, arbitrated onto a valid/ready port. Optional macro
//           BTN_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_event_arbiter
    import btn_pkg::*;
#(
    parameter int N_BTN       = 4,
    parameter int TICK_DIV    = 50000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 5000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_BTN-1:0]         btn_in,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [$clog2(N_BTN)-1:0] ev_btn,
    output logic                     ev_long,
    output logic [N_BTN-1:0]         pending,
    output logic [N_BTN-1:0]         overrun
);

    localparam int unsigned TICK_W = width_of(TICK_DIV);
    localparam int unsigned BTN_W  = width_of(N_BTN);

    localparam logic [TICK_W-1:0] c_tick_last = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] r_tick_cnt;
    logic [N_BTN-1:0]  r_pend;
    logic [N_BTN-1:0]  r_long;
    logic [N_BTN-1:0]  r_ovr;
    logic              r_ev_valid;
    logic [BTN_W-1:0]  r_ev_btn;
    logic              r_ev_long;

    logic              w_tick;
    logic [N_BTN-1:0]  w_raise;
    logic [N_BTN-1:0]  w_is_long;
    logic              w_load;
    logic              w_found;
    logic [BTN_W-1:0]  w_win;
    logic [N_BTN-1:0]  w_unload;

    assign w_tick = (r_tick_cnt == c_tick_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
            btn_press_classifier #(
                .DEBOUNCE_MS (DEBOUNCE_MS),
                .LONG_MS     (LONG_MS)
            ) u_classifier (
                .clk          (clk),
                .rst          (rst),
                .i_btn        (btn_in[gi]),
                .i_tick       (w_tick),
                .o_ev_raise   (w_raise[gi]),
                .o_ev_is_long (w_is_long[gi])
            );
        end
    endgenerate

    assign w_load = !r_ev_valid || ev_ready;

`ifdef BTN_ROUND_ROBIN_EN
    logic [BTN_W-1:0] r_rr_ptr;

    always_comb begin : p_arb
        logic [BTN_W-1:0] w_idx;
        w_idx   = '0;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < N_BTN; k++) begin
            w_idx = BTN_W'((int'(r_rr_ptr) + 1 + k) % N_BTN);
            if (!w_found && r_pend[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_load && w_found) begin
            r_rr_ptr <= w_win;
        end
    end
`else
    always_comb begin : p_arb
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (!w_found && r_pend[i]) begin
                w_found = 1'b1;
                w_win   = BTN_W'(i);
            end
        end
    end
`endif

    always_comb begin
        w_unload = '0;
        if (w_load && w_found) begin
            w_unload[w_win] = 1'b1;
        end
    end

    // A slot being unloaded this cycle can accept a new event without overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
            r_long <= '0;
            r_ovr  <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (w_raise[i]) begin
                    if (!r_pend[i] || w_unload[i]) begin
                        r_pend[i] <= 1'b1;
                        r_long[i] <= w_is_long[i];
                    end else begin
                        r_ovr[i] <= 1'b1;
                    end
                end else if (w_unload[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ev_valid <= 1'b0;
            r_ev_btn   <= '0;
            r_ev_long  <= 1'b0;
        end else if (w_load) begin
            r_ev_valid <= w_found;
            if (w_found) begin
                r_ev_btn  <= w_win;
                r_ev_long <= r_long[w_win];
            end
        end
    end

    assign ev_valid = r_ev_valid;
    assign ev_btn   = r_ev_btn;
    assign ev_long  = r_ev_long;
    assign pending  = r_pend;
    assign overrun  = r_ovr;

endmodule

`default_nettype wire

// File: tb/tb_button_event_arbiter.sv
// ============================================================================
// Module  : tb_button_event_arbiter
// Brief   : Scoreboard bench for button_event_arbiter: directed press scenarios
//           plus concurrent randomized presses against a duration-based model.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_event_arbiter;

    localparam int N_BTN       = 4;
    localparam int TICK_DIV    = 4;
    localparam int DEBOUNCE_MS = 3;
    localparam int LONG_MS     = 10;
    localparam int BTN_W       = $clog2(N_BTN);

`ifdef BTN_ROUND_ROBIN_EN
    localparam int CONT_FIRST  = 3;
    localparam int CONT_SECOND = 0;
`else
    localparam int CONT_FIRST  = 0;
    localparam int CONT_SECOND = 3;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [N_BTN-1:0] btn_in;
    logic             ev_valid;
    logic             ev_ready;
    logic [BTN_W-1:0] ev_btn;
    logic             ev_long;
    logic [N_BTN-1:0] pending;
    logic [N_BTN-1:0] overrun;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit rnd_ready   = 1'b0;

    // Expected press type per button, in press order (1 = LONG).
    bit q_exp [N_BTN][$];
    int acc_btn[$];
    int acc_cyc[$];

    bit               prev_stall = 1'b0;
    logic [BTN_W-1:0] prev_btn;
    logic             prev_long;
    bit               mon_exp_l;

    button_event_arbiter #(
        .N_BTN       (N_BTN),
        .TICK_DIV    (TICK_DIV),
        .DEBOUNCE_MS (DEBOUNCE_MS),
        .LONG_MS     (LONG_MS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_btn   (ev_btn),
        .ev_long  (ev_long),
        .pending  (pending),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ticks(input int n);
        clks(n * TICK_DIV);
    endtask

    function automatic int exp_left();
        int s = 0;
        for (int b = 0; b < N_BTN; b++) s += q_exp[b].size();
        return s;
    endfunction

    task automatic drain(input string name);
        int n = 0;
        while (n < 400 && exp_left() != 0) begin
            clks(1);
            n++;
        end
        chk(name, exp_left(), 0);
    endtask

    task automatic press(input int b, input int dur_ticks, input int gap_ticks);
        btn_in[b] = 1'b1;
        ticks(dur_ticks);
        btn_in[b] = 1'b0;
        ticks(gap_ticks);
    endtask

    // Random presses kept well clear of the SHORT/LONG boundary so the expected
    // type follows from the hold duration alone.
    task automatic rand_btn(input int b);
        for (int k = 0; k < 5; k++) begin
            bit lg;
            int d;
            int g;
            lg = 1'($urandom_range(1));
            d  = lg ? int'($urandom_range(18, 13)) : int'($urandom_range(7, 4));
            g  = int'($urandom_range(12, 6));
            q_exp[b].push_back(lg);
            press(b, d, g);
        end
    endtask

    // Monitor: consumes transfers and checks hold-stability during back-pressure.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(ev_valid), 1);
                chk("stall_btn", 32'(ev_btn), 32'(prev_btn));
                chk("stall_long", 32'(ev_long), 32'(prev_long));
            end
            if (ev_valid && ev_ready) begin
                if (q_exp[ev_btn].size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_event: got btn %0d long %0d, expected no event (t=%0t)",
                             ev_btn, ev_long, $time);
                end else begin
                    mon_exp_l = q_exp[ev_btn].pop_front();
                    chk($sformatf("event_long_btn%0d", ev_btn), 32'(ev_long), 32'(mon_exp_l));
                end
                acc_btn.push_back(int'(ev_btn));
                acc_cyc.push_back(cyc);
            end
            prev_stall = ev_valid && !ev_ready;
            prev_btn   = ev_btn;
            prev_long  = ev_long;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_ready) ev_ready = ($urandom_range(3) != 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        btn_in   = '0;
        ev_ready = 1'b0;
        clks(3);
        chk("rst_valid", 32'(ev_valid), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_btn", 32'(ev_btn), 0);
        rst = 1'b0;
        clks(2);
        chk("post_rst_valid", 32'(ev_valid), 0);

        // Short press on button 1.
        ev_ready = 1'b1;
        q_exp[1].push_back(1'b0);
        press(1, 6, 6);
        drain("short_drain");
        chk("short_pending", 32'(pending), 0);

        // Long press on button 0: event must arrive while still held.
        q_exp[0].push_back(1'b1);
        btn_in[0] = 1'b1;
        ticks(16);
        chk("long_before_release", 32'(q_exp[0].size()), 0);
        ticks(4);
        btn_in[0] = 1'b0;
        ticks(8);

        // Bounce on button 2.
        for (int k = 0; k < 10; k++) begin
            btn_in[2] = (k % 2 == 0);
            clks(4);
        end
        btn_in[2] = 1'b0;
        ticks(8);
        chk("bounce_pending", 32'(pending), 0);
        chk("bounce_valid", 32'(ev_valid), 0);

        // Contention between buttons 0 and 3.
        acc_btn.delete();
        acc_cyc.delete();
        q_exp[0].push_back(1'b0);
        q_exp[3].push_back(1'b0);
        btn_in[0] = 1'b1;
        btn_in[3] = 1'b1;
        ticks(6);
        btn_in[0] = 1'b0;
        btn_in[3] = 1'b0;
        ticks(6);
        drain("cont_drain");
        chk("cont_count", 32'(acc_btn.size()), 2);
        if (acc_btn.size() == 2) begin
            chk("cont_first", 32'(acc_btn[0]), CONT_FIRST);
            chk("cont_second", 32'(acc_btn[1]), CONT_SECOND);
            chk("cont_back_to_back", 32'(acc_cyc[1] - acc_cyc[0]), 1);
        end

        // Overrun on button 2 with the consumer stalled.
        ev_ready = 1'b0;
        press(2, 5, 6);
        chk("ovr1_valid", 32'(ev_valid), 1);
        chk("ovr1_btn", 32'(ev_btn), 2);
        chk("ovr1_long", 32'(ev_long), 0);
        chk("ovr1_pending", 32'(pending), 0);
        press(2, 5, 6);
        chk("ovr2_pending", 32'(pending), 32'h4);
        chk("ovr2_overrun", 32'(overrun), 0);
        press(2, 5, 6);
        chk("ovr3_overrun", 32'(overrun), 32'h4);
        chk("ovr3_btn", 32'(ev_btn), 2);
        chk("ovr3_valid", 32'(ev_valid), 1);
        q_exp[2].push_back(1'b0);
        q_exp[2].push_back(1'b0);
        ev_ready = 1'b1;
        drain("ovr_drain");
        clks(4);
        chk("ovr_pending_clear", 32'(pending), 0);
        chk("ovr_sticky", 32'(overrun), 32'h4);

        // Asynchronous reset while button 1 is in HELD.
        btn_in[1] = 1'b1;
        ticks(6);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(ev_valid), 0);
        chk("arst_pending", 32'(pending), 0);
        chk("arst_overrun", 32'(overrun), 0);
        clks(2);
        rst = 1'b0;
        q_exp[1].push_back(1'b1);
        ticks(16);
        chk("arst_long_event", 32'(q_exp[1].size()), 0);
        ticks(4);
        btn_in[1] = 1'b0;
        ticks(8);

        // Randomized concurrent presses with random back-pressure.
        rnd_ready = 1'b1;
        fork
            rand_btn(0);
            rand_btn(1);
            rand_btn(2);
            rand_btn(3);
        join
        rnd_ready = 1'b0;
        ev_ready  = 1'b1;
        ticks(6);
        drain("random_drain");
        chk("random_overrun", 32'(overrun), 0);
        chk("random_pending", 32'(pending), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
